// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared state type and defaults for the shot checker
package battleship_pkg;

  typedef enum logic [1:0] {IDLE, SHIP_SCAN, SHOT_SCAN, DECIDE} shot_state_t;

  localparam int CELLS_DEF = 16;

  function automatic int idx_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// rtl/cell_scan_counter.sv - cell index counter shared by the ship and shot scans
module cell_scan_counter
  import battleship_pkg::*;
#(
  parameter int CELLS = CELLS_DEF,
  parameter int IDX_W = idx_width(CELLS)
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (!clr_n_i || clear_i) begin
      idx_q <= '0;
    end else if (en_i) begin
      idx_q <= last_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(CELLS - 1));

endmodule

// File: rtl/shot_check_ctrl.sv
// rtl/shot_check_ctrl.sv - validates one attack vector per turn and scores it
module shot_check_ctrl
  import battleship_pkg::*;
#(
  parameter int CELLS   = CELLS_DEF,
  parameter int LIVES_W = 5
) (
  input  logic               clk_i,
  input  logic               clr_n_i,
  input  logic               load_ships_i,
  input  logic               start_i,
  input  logic [CELLS-1:0]   ship_map_i,
  input  logic [CELLS-1:0]   attack_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ok_o,
  output logic               hit_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic               alive_o,
  output logic [CELLS-1:0]   shot_hist_o
);

  localparam int IDX_W = idx_width(CELLS);

  shot_state_t        state_q;
  logic [CELLS-1:0]   snap_ship_q, snap_att_q, hist_q;
  logic [LIVES_W-1:0] lives_q, cnt_q, cnt_d;
  logic [1:0]         new_cnt_q, new_cnt_d;
  logic               removed_q, removed_d, hit_f_q, hit_f_d;
  logic               busy_q, done_q, ok_q, hit_q;
  logic [IDX_W-1:0]   idx;
  logic               last, accept;
  logic               a_b, h_b, s_b;

  cell_scan_counter #(.CELLS(CELLS), .IDX_W(IDX_W)) u_cnt (
    .clk_i   (clk_i),
    .clr_n_i (clr_n_i),
    .clear_i (state_q == IDLE),
    .en_i    ((state_q == SHIP_SCAN) || (state_q == SHOT_SCAN)),
    .idx_o   (idx),
    .last_o  (last)
  );

  assign a_b = snap_att_q[idx];
  assign h_b = hist_q[idx];
  assign s_b = snap_ship_q[idx];

  always_comb begin
    cnt_d     = cnt_q + LIVES_W'(s_b);
    new_cnt_d = new_cnt_q;
    if (a_b && !h_b && new_cnt_q != 2'd2) new_cnt_d = new_cnt_q + 2'd1;
    removed_d = removed_q | (!a_b && h_b);
    hit_f_d   = hit_f_q | (a_b && !h_b && s_b);
    accept    = (new_cnt_d == 2'd1) && !removed_d;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      state_q     <= IDLE;
      snap_ship_q <= '0;
      snap_att_q  <= '0;
      hist_q      <= '0;
      lives_q     <= '0;
      cnt_q       <= '0;
      new_cnt_q   <= '0;
      removed_q   <= 1'b0;
      hit_f_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_ships_i) begin
            snap_ship_q <= ship_map_i;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= SHIP_SCAN;
          end else if (start_i) begin
            snap_ship_q <= ship_map_i;
            snap_att_q  <= attack_in_i;
            new_cnt_q   <= '0;
            removed_q   <= 1'b0;
            hit_f_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SHOT_SCAN;
          end
        end
        SHIP_SCAN: begin
          cnt_q <= cnt_d;
          if (last) begin
            lives_q <= cnt_d;
            hist_q  <= '0;
            ok_q    <= 1'b0;
            hit_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHOT_SCAN: begin
          new_cnt_q <= new_cnt_d;
          removed_q <= removed_d;
          hit_f_q   <= hit_f_d;
          // Verdict is folded in with the last cell so it is valid while DECIDE shows done.
          if (last) begin
            ok_q    <= accept;
            done_q  <= 1'b1;
            state_q <= DECIDE;
            if (accept) begin
              hist_q <= snap_att_q;
              hit_q  <= hit_f_d;
              if (hit_f_d && lives_q != '0) lives_q <= lives_q - LIVES_W'(1);
            end else begin
              hit_q <= 1'b0;
            end
          end
        end
        DECIDE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign hit_o       = hit_q;
  assign lives_o     = lives_q;
  assign alive_o     = (lives_q != '0);
  assign shot_hist_o = hist_q;

endmodule

// File: tb/tb_shot_check_ctrl.sv
// tb/tb_shot_check_ctrl.sv - table-driven scoreboard bench for shot_check_ctrl
module tb_shot_check_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        load_ships = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ship_map = '0;
  logic [15:0] attack_in = '0;
  logic        busy, done, ok, hit, alive;
  logic [4:0]  lives;
  logic [15:0] shot_hist;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shot_check_ctrl #(.CELLS(16), .LIVES_W(5)) dut (
    .clk_i        (clk),
    .clr_n_i      (clr_n),
    .load_ships_i (load_ships),
    .start_i      (start),
    .ship_map_i   (ship_map),
    .attack_in_i  (attack_in),
    .busy_o       (busy),
    .done_o       (done),
    .ok_o         (ok),
    .hit_o        (hit),
    .lives_o      (lives),
    .alive_o      (alive),
    .shot_hist_o  (shot_hist)
  );

  typedef struct {
    logic        ld;
    logic        both;
    logic [15:0] ship;
    logic [15:0] att;
    logic        ok;
    logic        hit;
    logic [4:0]  lives;
    logic        alive;
    logic [15:0] hist;
  } vec_t;

  typedef struct {
    logic        ok;
    logic        hit;
    logic [4:0]  lives;
    logic        alive;
    logic [15:0] hist;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int row);
    exp_t e;
    int   n, dones, busy_n;
    e = '{v.ok, v.hit, v.lives, v.alive, v.hist};
    sb.push_back(e);
    @(negedge clk);
    ship_map  = v.ship;
    attack_in = v.att;
    if (v.ld) load_ships = 1'b1;
    if (!v.ld || v.both) start = 1'b1;
    n = 0;
    dones = 0;
    busy_n = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      load_ships = 1'b0;
      start      = 1'b0;
      n++;
      if (c == 3) begin
        // pulses and input churn while busy must not matter
        start      = 1'b1;
        load_ships = 1'b1;
        attack_in  = 16'($urandom);
        ship_map   = 16'($urandom);
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk($sformatf("row%0d latency", row), n, 17);
          if (sb.size() == 0) begin
            chk($sformatf("row%0d sb_empty", row), 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d ok", row), ok, e.ok);
            chk($sformatf("row%0d hit", row), hit, e.hit);
            chk($sformatf("row%0d lives", row), lives, e.lives);
            chk($sformatf("row%0d alive", row), alive, e.alive);
            chk($sformatf("row%0d hist", row), shot_hist, e.hist);
          end
        end
      end
    end
    chk($sformatf("row%0d done_count", row), dones, 1);
    chk($sformatf("row%0d busy_cycles", row), busy_n, v.ld ? 16 : 17);
  endtask

  initial begin
    int dones;
    //          ld    both  ship      att       ok    hit   lives alive hist
    tbl[0]  = '{1'b1, 1'b0, 16'h000F, 16'h0000, 1'b0, 1'b0, 5'd4, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h000F, 16'h0001, 1'b1, 1'b1, 5'd3, 1'b1, 16'h0001};
    tbl[2]  = '{1'b0, 1'b0, 16'h000F, 16'h0011, 1'b1, 1'b0, 5'd3, 1'b1, 16'h0011};
    tbl[3]  = '{1'b0, 1'b0, 16'h000F, 16'h0013, 1'b1, 1'b1, 5'd2, 1'b1, 16'h0013};
    tbl[4]  = '{1'b0, 1'b0, 16'h000F, 16'h0003, 1'b0, 1'b0, 5'd2, 1'b1, 16'h0013};
    tbl[5]  = '{1'b0, 1'b0, 16'h000F, 16'h0313, 1'b0, 1'b0, 5'd2, 1'b1, 16'h0013};
    tbl[6]  = '{1'b0, 1'b0, 16'h000F, 16'h0017, 1'b1, 1'b1, 5'd1, 1'b1, 16'h0017};
    tbl[7]  = '{1'b0, 1'b0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 5'd1, 1'b1, 16'h0017};
    tbl[8]  = '{1'b0, 1'b0, 16'h000F, 16'h001F, 1'b1, 1'b1, 5'd0, 1'b0, 16'h001F};
    tbl[9]  = '{1'b0, 1'b0, 16'h000F, 16'h003F, 1'b1, 1'b0, 5'd0, 1'b0, 16'h003F};
    tbl[10] = '{1'b0, 1'b0, 16'h000F, 16'h003F, 1'b0, 1'b0, 5'd0, 1'b0, 16'h003F};
    tbl[11] = '{1'b1, 1'b1, 16'h0007, 16'h0001, 1'b0, 1'b0, 5'd3, 1'b1, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 5'd1, 1'b1, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b1, 5'd0, 1'b0, 16'h0001};
    tbl[14] = '{1'b0, 1'b0, 16'h0003, 16'h0003, 1'b1, 1'b1, 5'd0, 1'b0, 16'h0003};
    tbl[15] = '{1'b0, 1'b0, 16'h8000, 16'h8003, 1'b1, 1'b1, 5'd0, 1'b0, 16'h8003};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ok_hit", {ok, hit}, 0);
    chk("reset lives_alive", {lives, alive}, 0);
    chk("reset hist", shot_hist, 0);
    clr_n = 1'b1;

    for (int i = 0; i < 16; i++) run_op(tbl[i], i);
    chk("sb drained", sb.size(), 0);

    // reset in the middle of a shot scan
    @(negedge clk);
    attack_in = 16'h0100;
    ship_map  = 16'h0100;
    start     = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("midscan busy before", busy, 1);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("midscan busy", busy, 0);
    chk("midscan outs", {done, ok, hit, alive}, 0);
    chk("midscan lives", lives, 0);
    chk("midscan hist", shot_hist, 0);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midscan no done", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
